uart_autobaud_rx: RTL and testbench

UART_AUTOBAUD_RX -- requirements
Module: uart_autobaud_rx

---
 rtl/uart_autobaud_rx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_autobaud_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud_rx.sv
// uart_autobaud_rx: 8N1 UART receiver that measures its bit period from a 0x55 sync character.
// Optional macro UART_AUTOBAUD_BREAK_RELOCK_EN: a 16-bit-time break while locked drops lock and recalibrates.
module uart_autobaud_rx #(
    parameter int CLOCK    = 100_000_000,
    parameter int MIN_BAUD = 9_600,
    parameter int MAX_BAUD = 921_600,
    localparam int CNT_W   = $clog2(8 * CLOCK / MIN_BAUD + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             uart_rx,
    input  logic             recal,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             locked,
    output logic [CNT_W-1:0] baud_div,
    output logic             rx_done,
    output logic [1:0]       rx_error
);

    localparam logic [CNT_W:0]   DIV_MIN  = (CNT_W + 1)'(CLOCK / MAX_BAUD);
    localparam logic [CNT_W:0]   DIV_MAX  = (CNT_W + 1)'(CLOCK / MIN_BAUD);
    localparam logic [CNT_W-1:0] MEAS_MAX = CNT_W'(8 * CLOCK / MIN_BAUD);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [2:0] {
        UNCAL   = 3'd0,
        MEASURE = 3'd1,
        IDLE    = 3'd2,
        START   = 3'd3,
        DATA    = 3'd4,
        STOP    = 3'd5
    } state_t;

    state_t           state_r;
    logic [1:0]       sync_r;
    logic             prev_r;
    logic [CNT_W-1:0] cnt_r;       // measurement counter, then bit timer
    logic [1:0]       edge_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             rx_s;
    logic             fall_s;
    logic [CNT_W:0]   div_s;
    logic [CNT_W-1:0] half_s;
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
    logic [CNT_W+3:0] low_cnt_r;
    logic             brk_r;
    logic [CNT_W+3:0] brk_len_s;
`endif

    // Synchronized line, edge detect, rounded divisor and half-bit offset.
    always_comb begin
        rx_s   = sync_r[1];
        fall_s = prev_r & ~rx_s;
        div_s  = ({1'b0, cnt_r} + (CNT_W + 1)'(3'd4)) >> 3'd3;
        half_s = baud_div >> 1'b1;
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
        brk_len_s = {baud_div, 4'b0000};
`endif
    end

    // Synchronizer, calibration/receive FSM and output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sync_r        <= 2'b11;
            prev_r        <= 1'b1;
            state_r       <= UNCAL;
            cnt_r         <= CNT_ZERO;
            edge_cnt_r    <= 2'd0;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            locked        <= 1'b0;
            baud_div      <= CNT_ZERO;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            rx_done       <= 1'b0;
            rx_error      <= 2'b00;
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
            low_cnt_r     <= {(CNT_W + 4){1'b0}};
            brk_r         <= 1'b0;
`endif
        end else begin
            sync_r  <= {sync_r[0], uart_rx};
            prev_r  <= rx_s;
            rx_done <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (recal) begin
                state_r <= UNCAL;
                locked  <= 1'b0;
            end
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
            else if (brk_r && rx_s) begin
                state_r <= UNCAL;
                locked  <= 1'b0;
            end
`endif
            else begin
                case (state_r)
                    UNCAL: begin
                        // Start at 1 so the count at the closing edge equals the full 8-bit span.
                        if (fall_s) begin
                            state_r    <= MEASURE;
                            cnt_r      <= CNT_ONE;
                            edge_cnt_r <= 2'd0;
                        end
                    end
                    MEASURE: begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r > MEAS_MAX) begin
                            state_r <= UNCAL;
                        end else if (fall_s) begin
                            if (edge_cnt_r == 2'd3) begin
                                if ((div_s >= DIV_MIN) && (div_s <= DIV_MAX)) begin
                                    baud_div <= div_s[CNT_W-1:0];
                                    locked   <= 1'b1;
                                    state_r  <= IDLE;
                                end else begin
                                    state_r  <= UNCAL;
                                end
                            end else begin
                                edge_cnt_r <= edge_cnt_r + 2'd1;
                            end
                        end
                    end
                    IDLE: begin
                        if (fall_s) begin
                            state_r <= START;
                            cnt_r   <= half_s;
                        end
                    end
                    START: begin
                        if (cnt_r != CNT_ZERO) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (!rx_s) begin
                            state_r   <= DATA;
                            cnt_r     <= baud_div - CNT_ONE;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            rx_error <= 2'b01;
                            state_r  <= IDLE;
                        end
                    end
                    DATA: begin
                        if (cnt_r != CNT_ZERO) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else begin
                            shift_r   <= {rx_s, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            cnt_r     <= baud_div - CNT_ONE;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (cnt_r != CNT_ZERO) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else begin
                            if (!rx_s) begin
                                rx_error <= 2'b10;
                            end else if (!m_axis_tvalid || m_axis_tready) begin
                                m_axis_tdata  <= shift_r;
                                m_axis_tvalid <= 1'b1;
                                rx_done       <= 1'b1;
                                rx_error      <= 2'b00;
                            end else begin
                                rx_error <= 2'b11;
                            end
                            // An edge coinciding with the stop sample opens the next frame directly.
                            if (fall_s) begin
                                state_r <= START;
                                cnt_r   <= half_s;
                            end else begin
                                state_r <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_r <= UNCAL;
                        locked  <= 1'b0;
                    end
                endcase
            end
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
            if (recal || !locked || rx_s) begin
                low_cnt_r <= {(CNT_W + 4){1'b0}};
            end else if (low_cnt_r != brk_len_s) begin
                low_cnt_r <= low_cnt_r + (CNT_W + 4)'(1'b1);
            end else begin
                low_cnt_r <= low_cnt_r;
            end
            if (recal || (brk_r && rx_s)) begin
                brk_r <= 1'b0;
            end else if (locked && !rx_s && (low_cnt_r == brk_len_s)) begin
                brk_r <= 1'b1;
            end else begin
                brk_r <= brk_r;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_autobaud_rx.sv
// Directed bench for uart_autobaud_rx: calibration, reception, flow control, errors, recal and reset.
module tb_uart_autobaud_rx;

    localparam int CLOCK    = 100_000_000;
    localparam int MIN_BAUD = 9_600;
    localparam int MAX_BAUD = 921_600;
    localparam int CNT_W    = $clog2(8 * CLOCK / MIN_BAUD + 1);
    localparam int BIT_115K = 868;
    localparam int BIT_921K = 109;
    localparam int BIT_57K  = 1736;
    localparam int BIT_FAST = 50;

    logic             aclk;
    logic             areset;
    logic             uart_rx;
    logic             recal;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             locked;
    logic [CNT_W-1:0] baud_div;
    logic             rx_done;
    logic [1:0]       rx_error;

    int         checks;
    int         passed;
    int         done_cnt;
    logic [7:0] beat_q[$];

    uart_autobaud_rx #(.CLOCK(CLOCK), .MIN_BAUD(MIN_BAUD), .MAX_BAUD(MAX_BAUD)) dut (
        .aclk(aclk), .areset(areset), .uart_rx(uart_rx), .recal(recal),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .locked(locked), .baud_div(baud_div), .rx_done(rx_done), .rx_error(rx_error)
    );

    always #5 aclk = ~aclk;

    // Record handshakes and done pulses away from the active edge.
    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) beat_q.push_back(m_axis_tdata);
        if (rx_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_v);
        uart_rx = 1'b0;
        tick(bc);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(bc);
        end
        uart_rx = stop_v;
        tick(bc);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        uart_rx = 1'b1;
        tick(4);
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else passed++;
        checks++; if (baud_div !== '0) $display("FAIL reset_baud_div: got %0d want 0", baud_div); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); else passed++;
        checks++; if (m_axis_tdata !== 8'h00) $display("FAIL reset_tdata: got %0h want 0", m_axis_tdata); else passed++;
        checks++; if (rx_done !== 1'b0) $display("FAIL reset_rx_done: got %0b want 0", rx_done); else passed++;
        checks++; if (rx_error !== 2'b00) $display("FAIL reset_rx_error: got %0b want 00", rx_error); else passed++;
        areset = 1'b0;
        tick(4);
    endtask

    task automatic test_calibrate();
        send_byte(8'h55, BIT_115K, 1'b1);
        tick(BIT_115K);
        checks++; if (locked !== 1'b1) $display("FAIL cal_locked: got %0b want 1", locked); else passed++;
        checks++; if (int'(baud_div) < 867 || int'(baud_div) > 869) $display("FAIL cal_baud_div: got %0d want 868+-1", baud_div); else passed++;
        checks++; if (beat_q.size() != 0 || m_axis_tvalid !== 1'b0) $display("FAIL cal_no_beat: got %0d beats want 0", beat_q.size()); else passed++;
        checks++; if (done_cnt != 0) $display("FAIL cal_no_done: got %0d want 0", done_cnt); else passed++;
    endtask

    task automatic test_bytes();
        int base;
        int d0;
        base = beat_q.size();
        d0 = done_cnt;
        m_axis_tready = 1'b1;
        send_byte(8'hA3, BIT_115K, 1'b1);
        send_byte(8'h0F, BIT_115K, 1'b1);
        tick(BIT_115K);
        checks++; if (beat_q.size() != base + 2) $display("FAIL bytes_count: got %0d want %0d", beat_q.size(), base + 2); else passed++;
        checks++; if (beat_q[base] !== 8'hA3) $display("FAIL bytes_first: got %0h want a3", beat_q[base]); else passed++;
        checks++; if (beat_q[base + 1] !== 8'h0F) $display("FAIL bytes_second: got %0h want 0f", beat_q[base + 1]); else passed++;
        checks++; if (done_cnt - d0 != 2) $display("FAIL bytes_done: got %0d want 2", done_cnt - d0); else passed++;
        checks++; if (rx_error !== 2'b00) $display("FAIL bytes_error: got %0b want 00", rx_error); else passed++;
    endtask

    task automatic test_overrun();
        int base;
        int d0;
        base = beat_q.size();
        d0 = done_cnt;
        m_axis_tready = 1'b0;
        send_byte(8'h11, BIT_115K, 1'b1);
        send_byte(8'h22, BIT_115K, 1'b1);
        tick(BIT_115K);
        checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL ovr_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
        checks++; if (m_axis_tdata !== 8'h11) $display("FAIL ovr_tdata: got %0h want 11", m_axis_tdata); else passed++;
        checks++; if (rx_error !== 2'b11) $display("FAIL ovr_error: got %0b want 11", rx_error); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL ovr_done: got %0d want 1", done_cnt - d0); else passed++;
        m_axis_tready = 1'b1;
        tick(4);
        checks++; if (beat_q.size() != base + 1 || beat_q[base] !== 8'h11) $display("FAIL ovr_beat: got %0d beats want one 11", beat_q.size() - base); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL ovr_tvalid_fall: got %0b want 0", m_axis_tvalid); else passed++;
    endtask

    task automatic test_errors();
        int base;
        int d0;
        base = beat_q.size();
        d0 = done_cnt;
        uart_rx = 1'b0;
        tick(300);
        uart_rx = 1'b1;
        tick(2 * BIT_115K);
        checks++; if (rx_error !== 2'b01) $display("FAIL glitch_error: got %0b want 01", rx_error); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0 || beat_q.size() != base) $display("FAIL glitch_no_beat: got tvalid %0b", m_axis_tvalid); else passed++;
        send_byte(8'h5A, BIT_115K, 1'b0);
        tick(BIT_115K);
        checks++; if (rx_error !== 2'b10) $display("FAIL stop_error: got %0b want 10", rx_error); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0 || beat_q.size() != base) $display("FAIL stop_no_beat: got tvalid %0b", m_axis_tvalid); else passed++;
        checks++; if (done_cnt != d0) $display("FAIL err_no_done: got %0d want %0d", done_cnt, d0); else passed++;
    endtask

    task automatic test_recal_reject();
        int base;
        base = beat_q.size();
        recal = 1'b1;
        tick(1);
        recal = 1'b0;
        checks++; if (locked !== 1'b0) $display("FAIL recal_unlock: got %0b want 0", locked); else passed++;
        tick(10);
        send_byte(8'h55, BIT_FAST, 1'b1);
        tick(4 * BIT_FAST);
        checks++; if (locked !== 1'b0) $display("FAIL reject_locked: got %0b want 0", locked); else passed++;
        checks++; if (int'(baud_div) < 867 || int'(baud_div) > 869) $display("FAIL reject_baud_div: got %0d want 868+-1", baud_div); else passed++;
        send_byte(8'h55, BIT_921K, 1'b1);
        tick(2 * BIT_921K);
        checks++; if (locked !== 1'b1) $display("FAIL fast_locked: got %0b want 1", locked); else passed++;
        checks++; if (int'(baud_div) < 108 || int'(baud_div) > 110) $display("FAIL fast_baud_div: got %0d want 109+-1", baud_div); else passed++;
        checks++; if (beat_q.size() != base) $display("FAIL fast_no_beat: got %0d beats want 0", beat_q.size() - base); else passed++;
    endtask

    task automatic test_back_to_back();
        int base;
        int d0;
        base = beat_q.size();
        d0 = done_cnt;
        send_byte(8'hC3, BIT_921K, 1'b1);
        send_byte(8'h3C, BIT_921K, 1'b1);
        tick(BIT_921K);
        checks++; if (beat_q.size() != base + 2) $display("FAIL b2b_count: got %0d want %0d", beat_q.size(), base + 2); else passed++;
        checks++; if (beat_q[base] !== 8'hC3 || beat_q[base + 1] !== 8'h3C) $display("FAIL b2b_data: got %0h %0h want c3 3c", beat_q[base], beat_q[base + 1]); else passed++;
        checks++; if (done_cnt - d0 != 2) $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); else passed++;
    endtask

    task automatic test_break();
        int base;
        base = beat_q.size();
        uart_rx = 1'b0;
        tick(20 * BIT_921K);
        uart_rx = 1'b1;
        tick(4 * BIT_921K);
        checks++; if (beat_q.size() != base) $display("FAIL break_no_beat: got %0d beats want 0", beat_q.size() - base); else passed++;
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
        checks++; if (locked !== 1'b0) $display("FAIL break_unlock: got %0b want 0", locked); else passed++;
        send_byte(8'h55, BIT_57K, 1'b1);
        tick(BIT_57K);
        checks++; if (locked !== 1'b1) $display("FAIL relock_locked: got %0b want 1", locked); else passed++;
        checks++; if (int'(baud_div) < 1735 || int'(baud_div) > 1737) $display("FAIL relock_baud_div: got %0d want 1736+-1", baud_div); else passed++;
`else
        checks++; if (rx_error !== 2'b10) $display("FAIL break_error: got %0b want 10", rx_error); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL break_keep_lock: got %0b want 1", locked); else passed++;
`endif
    endtask

    task automatic test_reset_midframe();
        int base;
        int d0;
        int bc;
`ifdef UART_AUTOBAUD_BREAK_RELOCK_EN
        bc = BIT_57K;
`else
        bc = BIT_921K;
`endif
        base = beat_q.size();
        d0 = done_cnt;
        uart_rx = 1'b0;
        tick(bc);
        uart_rx = 1'b1;
        tick(bc);
        uart_rx = 1'b0;
        tick(bc / 2);
        areset = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        areset = 1'b0;
        tick(2 * bc);
        checks++; if (m_axis_tvalid !== 1'b0 || beat_q.size() != base) $display("FAIL midrst_no_beat: got tvalid %0b", m_axis_tvalid); else passed++;
        checks++; if (done_cnt != d0) $display("FAIL midrst_no_done: got %0d want %0d", done_cnt, d0); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL midrst_locked: got %0b want 0", locked); else passed++;
        checks++; if (baud_div !== '0) $display("FAIL midrst_baud_div: got %0d want 0", baud_div); else passed++;
    endtask

    initial begin
        aclk = 1'b0;
        areset = 1'b1;
        uart_rx = 1'b1;
        recal = 1'b0;
        m_axis_tready = 1'b0;
        checks = 0;
        passed = 0;
        done_cnt = 0;
        test_reset();
        test_calibrate();
        test_bytes();
        test_overrun();
        test_errors();
        test_recal_reject();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
